// File: rtl/imu_bias_cal_pkg.sv
// Shared state encoding and saturating-subtract helper for the IMU gyro bias calibrator.
package imu_bias_cal_pkg;

    typedef enum logic [1:0] {
        S_DISCARD = 2'd0,
        S_ACC     = 2'd1,
        S_BIAS    = 2'd2,
        S_RUN     = 2'd3
    } state_t;

    // a - b evaluated one bit wider than the operands, clamped to a signed width-bit range
    function automatic logic signed [31:0] sat_sub(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int width);
        logic signed [32:0] d;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        d  = $signed({a[31], a}) - $signed({b[31], b});
        hi = (33'sd1 <<< (width - 1)) - 33'sd1;
        lo = -(33'sd1 <<< (width - 1));
        if (d > hi)
            return hi[31:0];
        else if (d < lo)
            return lo[31:0];
        else
            return d[31:0];
    endfunction

endpackage

// File: rtl/imu_bias_cal_ch.sv
// One gyro axis: sums calibration samples, latches the floored mean as bias and
// emits bias-corrected, saturated samples one cycle after each run-mode strobe.
module bias_acc_ch
    import imu_bias_cal_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CAL_LOG2 = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    acc_clr,
    input  logic                    acc_en,
    input  logic                    bias_ld,
    input  logic                    out_en,
    input  logic signed [WIDTH-1:0] sample,
    output logic signed [WIDTH-1:0] bias,
    output logic signed [WIDTH-1:0] corr
);

    logic signed [WIDTH+CAL_LOG2-1:0] acc;
    logic signed [WIDTH+CAL_LOG2-1:0] sample_ext;
    logic signed [31:0]               sample_32;
    logic signed [31:0]               bias_32;

    assign sample_ext = {{CAL_LOG2{sample[WIDTH-1]}}, sample};
    assign sample_32  = {{(32-WIDTH){sample[WIDTH-1]}}, sample};
    assign bias_32    = {{(32-WIDTH){bias[WIDTH-1]}}, bias};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            bias <= '0;
            corr <= '0;
        end else begin
            if (acc_clr)
                acc <= '0;
            else if (acc_en)
                acc <= acc + sample_ext;
            // Taking the WIDTH bits above the fraction is an arithmetic shift with floor rounding
            if (bias_ld)
                bias <= acc[CAL_LOG2 +: WIDTH];
            if (out_en)
                corr <= WIDTH'(sat_sub(sample_32, bias_32, WIDTH));
        end
    end

endmodule

// File: rtl/imu_bias_cal.sv
// Gyro bias calibrator: drops settling samples, averages 2^CAL_LOG2 gyro samples, then
// forwards bias-corrected samples with 1-cycle latency. No backpressure: strobes outside run mode are consumed or dropped.
module imu_bias_cal
    import imu_bias_cal_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CAL_LOG2 = 6,
    parameter int DISCARD  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] accel_x_in,
    input  logic signed [WIDTH-1:0] accel_y_in,
    input  logic signed [WIDTH-1:0] accel_z_in,
    input  logic signed [WIDTH-1:0] gyro_x_in,
    input  logic signed [WIDTH-1:0] gyro_y_in,
    input  logic                    recal,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] accel_x_out,
    output logic signed [WIDTH-1:0] accel_y_out,
    output logic signed [WIDTH-1:0] accel_z_out,
    output logic signed [WIDTH-1:0] gyro_x_out,
    output logic signed [WIDTH-1:0] gyro_y_out,
    output logic                    cal_done,
    output logic signed [WIDTH-1:0] gyro_x_bias,
    output logic signed [WIDTH-1:0] gyro_y_bias
);

    localparam int CW_ACC  = CAL_LOG2 + 1;
    localparam int CW_DISC = $clog2(DISCARD + 1);
    localparam int CW      = (CW_ACC > CW_DISC) ? CW_ACC : CW_DISC;
    localparam logic [CW-1:0] DISC_LAST = CW'((DISCARD > 0) ? DISCARD - 1 : 0);
    localparam logic [CW-1:0] ACC_LAST  = CW'((1 << CAL_LOG2) - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          acc_clr, acc_en, bias_ld, out_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_DISCARD;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        bias_ld   = 1'b0;
        out_en    = 1'b0;
        case (state)
            S_DISCARD: begin
                if (DISCARD == 0) begin
                    state_nxt = S_ACC;
                end else if (in_valid) begin
                    if (cnt == DISC_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = S_ACC;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            S_ACC: begin
                if (in_valid) begin
                    acc_en = 1'b1;
                    if (cnt == ACC_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = S_BIAS;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            S_BIAS: begin
                bias_ld   = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                out_en = in_valid;
            end
            default: state_nxt = S_DISCARD;
        endcase
        // A restart request overrides whatever the current state wanted to do with this cycle
        if (recal) begin
            state_nxt = S_DISCARD;
            cnt_nxt   = '0;
            acc_clr   = 1'b1;
            acc_en    = 1'b0;
            bias_ld   = 1'b0;
            out_en    = 1'b0;
        end
    end

    assign cal_done = (state == S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            accel_x_out <= '0;
            accel_y_out <= '0;
            accel_z_out <= '0;
        end else begin
            out_valid <= out_en;
            if (out_en) begin
                accel_x_out <= accel_x_in;
                accel_y_out <= accel_y_in;
                accel_z_out <= accel_z_in;
            end
        end
    end

    bias_acc_ch #(.WIDTH(WIDTH), .CAL_LOG2(CAL_LOG2)) u_ch_x (
        .clk     (clk),
        .rst_n   (rst_n),
        .acc_clr (acc_clr),
        .acc_en  (acc_en),
        .bias_ld (bias_ld),
        .out_en  (out_en),
        .sample  (gyro_x_in),
        .bias    (gyro_x_bias),
        .corr    (gyro_x_out)
    );

    bias_acc_ch #(.WIDTH(WIDTH), .CAL_LOG2(CAL_LOG2)) u_ch_y (
        .clk     (clk),
        .rst_n   (rst_n),
        .acc_clr (acc_clr),
        .acc_en  (acc_en),
        .bias_ld (bias_ld),
        .out_en  (out_en),
        .sample  (gyro_y_in),
        .bias    (gyro_y_bias),
        .corr    (gyro_y_out)
    );

endmodule

// File: tb/tb_imu_bias_cal.sv
// Directed + randomized bench for imu_bias_cal against a sample-counting reference model.
module tb_imu_bias_cal;

    localparam int W    = 16;
    localparam int CL   = 6;
    localparam int DISC = 8;
    localparam int NACC = 1 << CL;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic recal = 1'b0;
    logic signed [W-1:0] accel_x_in = '0, accel_y_in = '0, accel_z_in = '0;
    logic signed [W-1:0] gyro_x_in = '0, gyro_y_in = '0;
    logic out_valid, cal_done;
    logic signed [W-1:0] accel_x_out, accel_y_out, accel_z_out;
    logic signed [W-1:0] gyro_x_out, gyro_y_out, gyro_x_bias, gyro_y_bias;

    always #5 clk = ~clk;

    imu_bias_cal #(.WIDTH(W), .CAL_LOG2(CL), .DISCARD(DISC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .accel_x_in  (accel_x_in),
        .accel_y_in  (accel_y_in),
        .accel_z_in  (accel_z_in),
        .gyro_x_in   (gyro_x_in),
        .gyro_y_in   (gyro_y_in),
        .recal       (recal),
        .out_valid   (out_valid),
        .accel_x_out (accel_x_out),
        .accel_y_out (accel_y_out),
        .accel_z_out (accel_z_out),
        .gyro_x_out  (gyro_x_out),
        .gyro_y_out  (gyro_y_out),
        .cal_done    (cal_done),
        .gyro_x_bias (gyro_x_bias),
        .gyro_y_bias (gyro_y_bias)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: how many settling samples remain, how many averaged, running sums
    int     disc_left, acc_cnt;
    longint sum_x, sum_y;
    bit     pend, running;
    int     m_ov, m_done, m_ax, m_ay, m_az, m_gx, m_gy, m_bx, m_by;

    function automatic int clamp(input int d);
        if (d > 32767) return 32767;
        if (d < -32768) return -32768;
        return d;
    endfunction

    function automatic int floor_avg(input longint s);
        longint q;
        q = s / NACC;
        if ((s % NACC) != 0 && s < 0) q = q - 1;
        return int'(q);
    endfunction

    task automatic model_reset();
        disc_left = DISC; acc_cnt = 0; sum_x = 0; sum_y = 0; pend = 0; running = 0;
        m_ov = 0; m_done = 0; m_ax = 0; m_ay = 0; m_az = 0; m_gx = 0; m_gy = 0; m_bx = 0; m_by = 0;
    endtask

    task automatic model_upd(input bit v, input bit r, input int ax, ay, az, gx, gy);
        m_ov = 0;
        if (r) begin
            disc_left = DISC; acc_cnt = 0; sum_x = 0; sum_y = 0; pend = 0; running = 0;
        end else if (pend) begin
            m_bx = floor_avg(sum_x); m_by = floor_avg(sum_y);
            pend = 0; running = 1;
        end else if (running) begin
            if (v) begin
                m_ov = 1; m_ax = ax; m_ay = ay; m_az = az;
                m_gx = clamp(gx - m_bx); m_gy = clamp(gy - m_by);
            end
        end else if (v) begin
            if (disc_left > 0) begin
                disc_left--;
            end else begin
                sum_x += gx; sum_y += gy; acc_cnt++;
                if (acc_cnt == NACC) pend = 1;
            end
        end
        m_done = running ? 1 : 0;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, m_ov);
        chk({tag, ".cal_done"}, {31'd0, cal_done}, m_done);
        chk({tag, ".bias_x"}, gyro_x_bias, m_bx);
        chk({tag, ".bias_y"}, gyro_y_bias, m_by);
        chk({tag, ".accel_x"}, accel_x_out, m_ax);
        chk({tag, ".accel_y"}, accel_y_out, m_ay);
        chk({tag, ".accel_z"}, accel_z_out, m_az);
        chk({tag, ".gyro_x"}, gyro_x_out, m_gx);
        chk({tag, ".gyro_y"}, gyro_y_out, m_gy);
    endtask

    function automatic logic signed [15:0] rnd();
        return 16'($urandom);
    endfunction

    task automatic step(input string tag, input bit v, input bit r,
                        input logic signed [15:0] ax, ay, az, gx, gy);
        in_valid = v; recal = r;
        accel_x_in = ax; accel_y_in = ay; accel_z_in = az; gyro_x_in = gx; gyro_y_in = gy;
        @(posedge clk);
        model_upd(v, r, int'(ax), int'(ay), int'(az), int'(gx), int'(gy));
        #1;
        chk_all(tag);
        in_valid = 1'b0; recal = 1'b0;
    endtask

    task automatic idle(input string tag, input int n);
        repeat (n) step(tag, 1'b0, 1'b0, rnd(), rnd(), rnd(), rnd(), rnd());
    endtask

    task automatic feed(input string tag, input int n, input bit fix_x, input logic signed [15:0] gx,
                        input bit fix_y, input logic signed [15:0] gy, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) idle(tag, 1);
            step(tag, 1'b1, 1'b0, rnd(), rnd(), rnd(), fix_x ? gx : rnd(), fix_y ? gy : rnd());
        end
    endtask

    task automatic run_random(input string tag, input int n);
        for (int i = 0; i < n; i++)
            step(tag, ($urandom_range(0, 3) != 0), 1'b0, rnd(), rnd(), rnd(), rnd(), rnd());
    endtask

    initial begin
        model_reset();
        #12;
        chk_all("reset");
        rst_n = 1'b1;

        // Initial calibration: settling at 1000, then constant 100 / -50
        feed("disc", DISC, 1'b1, 16'sd1000, 1'b0, 16'sd0, 1'b1);
        feed("acc", NACC, 1'b1, 16'sd100, 1'b1, -16'sd50, 1'b0);
        idle("bias", 2);
        chk("cal1.bias_x", gyro_x_bias, 100);
        chk("cal1.bias_y", gyro_y_bias, -50);

        step("run1", 1'b1, 1'b0, 16'sd1, 16'sd2, 16'sd16384, 16'sd150, -16'sd50);
        chk("run1.gx", gyro_x_out, 50);
        chk("run1.gy", gyro_y_out, 0);
        chk("run1.az", accel_z_out, 16384);
        idle("hold", 1);
        run_random("runrnd", 20);

        // Recal colliding with a valid sample in run mode
        step("recal_v", 1'b1, 1'b1, rnd(), rnd(), rnd(), rnd(), rnd());
        chk("recal_v.done", {31'd0, cal_done}, 0);
        chk("recal_v.bias_x", gyro_x_bias, 100);

        // Bias -100 / 100, then drive positive and negative full-scale
        feed("disc2", DISC, 1'b0, 16'sd0, 1'b0, 16'sd0, 1'b1);
        feed("acc2", NACC, 1'b1, -16'sd100, 1'b1, 16'sd100, 1'b1);
        idle("bias2", 2);
        step("satp", 1'b1, 1'b0, rnd(), rnd(), rnd(), 16'sd32767, -16'sd32768);
        chk("satp.gx", gyro_x_out, 32767);
        chk("satp.gy", gyro_y_out, -32768);

        step("recal2", 1'b0, 1'b1, rnd(), rnd(), rnd(), rnd(), rnd());
        feed("disc3", DISC, 1'b0, 16'sd0, 1'b0, 16'sd0, 1'b0);
        feed("acc3", NACC, 1'b1, 16'sd100, 1'b1, -16'sd100, 1'b0);
        idle("bias3", 2);
        step("satn", 1'b1, 1'b0, rnd(), rnd(), rnd(), -16'sd32768, 16'sd32767);
        chk("satn.gx", gyro_x_out, -32768);
        chk("satn.gy", gyro_y_out, 32767);

        // Floor rounding of a negative mean; a strobe in the bias cycle is dropped
        step("recal3", 1'b0, 1'b1, rnd(), rnd(), rnd(), rnd(), rnd());
        feed("disc4", DISC, 1'b0, 16'sd0, 1'b0, 16'sd0, 1'b0);
        for (int i = 0; i < NACC; i++)
            step("floor", 1'b1, 1'b0, rnd(), rnd(), rnd(), (i % 2 == 1) ? -16'sd2 : -16'sd1, rnd());
        step("biasdrop", 1'b1, 1'b0, rnd(), rnd(), rnd(), rnd(), rnd());
        chk("floor.bias_x", gyro_x_bias, -2);
        run_random("runrnd2", 15);

        // Asynchronous reset partway through accumulation
        step("recal4", 1'b0, 1'b1, rnd(), rnd(), rnd(), rnd(), rnd());
        feed("disc5", DISC, 1'b0, 16'sd0, 1'b0, 16'sd0, 1'b1);
        feed("acc5", 30, 1'b0, 16'sd0, 1'b0, 16'sd0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all("arst");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        feed("disc6", DISC, 1'b0, 16'sd0, 1'b0, 16'sd0, 1'b1);
        feed("acc6", NACC - 1, 1'b0, 16'sd0, 1'b0, 16'sd0, 1'b1);
        chk("acc6.not_done", {31'd0, cal_done}, 0);
        feed("acc6", 1, 1'b0, 16'sd0, 1'b0, 16'sd0, 1'b0);
        idle("bias6", 2);
        chk("acc6.done", {31'd0, cal_done}, 1);
        run_random("runrnd3", 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
